// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, canonical NOP, default reset PC,
// register-field positions and the IF/ID payload layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    // A bubble is also the reset image of IF/ID, so flush and reset share one value.
    localparam ifid_t IFID_BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with load/hold/flush; used for IF/ID and later ID/EX.
// Priority per edge: rst > flush > load > hold. Flush loads the same image as reset.
module ifid_reg #(
    parameter int         W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, PC+4 incrementer and the IF/ID register.
// Optional perf counters (stall_cnt, flush_cnt) are built when IF_PERF_EN is defined.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            Write_IFID,
    input  logic            PCSrc_EX,
    input  logic [XLEN-1:0] target_EX,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_IFID,
    output logic [XLEN-1:0] pc4_IFID,
    output logic [XLEN-1:0] instr_IFID,
    output logic            valid_IFID,
    output logic [4:0]      rs1_IFID,
    output logic [4:0]      rs2_IFID
`ifdef IF_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    // Stall controls are level enables, not handshakes: PCWrite=0 holds the PC,
    // Write_IFID=0 holds IF/ID, each acted on independently. PCSrc_EX overrides both.
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = target_EX & ~32'd3;

    always_comb begin
        pc_next = pc_q;
        if (PCSrc_EX) begin
            pc_next = redirect_pc;
        end else if (PCWrite) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    always_comb begin
        ifid_d.pc    = pc_q;
        ifid_d.pc4   = pc_plus4;
        ifid_d.instr = imem_rdata;
        ifid_d.valid = 1'b1;
    end

    ifid_reg #(
        .W       ($bits(ifid_t)),
        .RST_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (PCSrc_EX),
        .load  (Write_IFID),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr  = pc_q;
    assign pc_IFID    = ifid_q.pc;
    assign pc4_IFID   = ifid_q.pc4;
    assign instr_IFID = ifid_q.instr;
    assign valid_IFID = ifid_q.valid;
    assign rs1_IFID   = ifid_q.instr[RS1_MSB:RS1_LSB];
    assign rs2_IFID   = ifid_q.instr[RS2_MSB:RS2_LSB];

`ifdef IF_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (PCSrc_EX) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
        end else if (!PCWrite) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, free run, stall, redirect, wrap, rs fields,
// reset mid-stall/redirect, and perf counters when IF_PERF_EN is defined.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        Write_IFID;
    logic        PCSrc_EX;
    logic [31:0] target_EX;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IFID;
    logic [31:0] pc4_IFID;
    logic [31:0] instr_IFID;
    logic        valid_IFID;
    logic [4:0]  rs1_IFID;
    logic [4:0]  rs2_IFID;
`ifdef IF_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    if_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .Write_IFID (Write_IFID),
        .PCSrc_EX   (PCSrc_EX),
        .target_EX  (target_EX),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_IFID    (pc_IFID),
        .pc4_IFID   (pc4_IFID),
        .instr_IFID (instr_IFID),
        .valid_IFID (valid_IFID),
        .rs1_IFID   (rs1_IFID),
        .rs2_IFID   (rs2_IFID)
`ifdef IF_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word 0x40 is add x0,x1,x2; all others tag their address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0020_8033 : (32'hA000_0000 | a);
    endfunction
    assign imem_rdata = mem(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change #1 after the rising edge; outputs sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic pcw, input logic wif,
                         input logic src, input logic [31:0] tgt);
        rst = r; PCWrite = pcw; Write_IFID = wif; PCSrc_EX = src; target_EX = tgt;
    endtask

    task automatic check_reset_image(input string tag);
        check({tag, "_addr"},  imem_addr,  32'h100);
        check({tag, "_valid"}, {31'd0, valid_IFID}, 32'd0);
        check({tag, "_instr"}, instr_IFID, 32'h13);
        check({tag, "_pc"},    pc_IFID,    32'h0);
        check({tag, "_pc4"},   pc4_IFID,   32'h0);
        check({tag, "_rs1"},   {27'd0, rs1_IFID}, 32'd0);
        check({tag, "_rs2"},   {27'd0, rs2_IFID}, 32'd0);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        check_reset_image("rst");

        // Free run from 0x100
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        for (int i = 0; i < 2; i++) begin
            step();
            check("run_addr", imem_addr, exp_q.pop_front());
        end
        check("run_pc",    pc_IFID,    32'h104);
        check("run_pc4",   pc4_IFID,   32'h108);
        check("run_instr", instr_IFID, 32'hA000_0104);
        check("run_valid", {31'd0, valid_IFID}, 32'd1);

        // Redirect to 0x10, then stall with IF/ID holding PC 0x10
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h10);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("pre_stall_pc", pc_IFID, 32'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  imem_addr,  32'h14);
            check("stall_pc",    pc_IFID,    32'h10);
            check("stall_instr", instr_IFID, 32'hA000_0010);
            check("stall_valid", {31'd0, valid_IFID}, 32'd1);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("resume_addr", imem_addr, 32'h18);
        check("resume_pc",   pc_IFID,   32'h14);

        // Redirect with misaligned target while stalled
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0203);
        step();
        check("redir_addr",  imem_addr,  32'h200);
        check("redir_valid", {31'd0, valid_IFID}, 32'd0);
        check("redir_instr", instr_IFID, 32'h13);
        check("redir_pc",    pc_IFID,    32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("tgt_pc",    pc_IFID,    32'h200);
        check("tgt_valid", {31'd0, valid_IFID}, 32'd1);
        check("tgt_instr", instr_IFID, 32'hA000_0200);
        check("tgt_addr",  imem_addr,  32'h204);

        // Wrap-around at the top of the address space
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_pc",    pc_IFID,   32'hFFFF_FFFC);
        check("wrap_pc4",   pc4_IFID,  32'h0);

        // rs fields from add x0,x1,x2 at 0x40
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("rs_instr", instr_IFID, 32'h0020_8033);
        check("rs1",      {27'd0, rs1_IFID}, 32'd1);
        check("rs2",      {27'd0, rs2_IFID}, 32'd2);

        // Mismatched pair: PC advances, IF/ID holds
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check("mis_addr", imem_addr, 32'h48);
        check("mis_pc",   pc_IFID,   32'h40);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check("mis2_addr", imem_addr, 32'h48);
        check("mis2_pc",   pc_IFID,   32'h48);

        // Reset asserted mid-stall with a pending redirect: reset wins
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        step();
        check_reset_image("rst_mid");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("post_rst_addr", imem_addr, 32'h104);
        check("post_rst_pc",   pc_IFID,   32'h100);

`ifdef IF_PERF_EN
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("perf_rst_stall", stall_cnt, 32'd0);
        check("perf_rst_flush", flush_cnt, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("perf_stall", stall_cnt, 32'd4);
        check("perf_flush", flush_cnt, 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("perf_clr_stall", stall_cnt, 32'd0);
        check("perf_clr_flush", flush_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
